// File: rtl/pipe_stage_pkg.sv
// Shared types for the pipeline stage controller: FSM state encoding and occupancy codes.
// Imported by pipe_stage_ctrl; no logic of its own.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_of(input stage_state_t s);
    case (s)
      BUSY:    occ_of = OCC_BUSY;
      FULL:    occ_of = OCC_FULL;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/stage_data_reg.sv
// WIDTH-wide enable register built from per-bit enable DFFs, sync active-high clear.
// Latency: 1 cycle from en to q. No flow control of its own; the controller drives en.
module stage_data_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic q_bit;
      always_ff @(posedge clk) begin
        if (reset)   q_bit <= 1'b0;
        else if (en) q_bit <= d[i];
      end
      assign q[i] = q_bit;
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Valid/ready stage controller with main+skid registers; 1-cycle latency, full throughput.
// in_ready is decoded from registered state only, so backpressure releases one cycle late.
// Optional PIPE_STALL_CNT_EN adds a 32-bit stall_cycles counter (out_valid & !out_ready).
module pipe_stage_ctrl
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0]      stall_cycles,
`endif
  output logic [1:0]       occupancy
);

  stage_state_t state, state_nxt;
  logic             load_in, load_skid, main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_valid) state_nxt = BUSY;
        BUSY: begin
          if (in_valid && !out_ready)      state_nxt = FULL;
          else if (!in_valid && out_ready) state_nxt = EMPTY;
        end
        FULL:    if (out_ready) state_nxt = BUSY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    occupancy = occ_of(state);
  end

  // Items offered during a flush are dropped, so no data wall is loaded in that cycle.
  assign load_in   = !flush && in_valid &&
                     ((state == EMPTY) || ((state == BUSY) && out_ready));
  assign load_skid = !flush && (state == FULL) && out_ready;
  assign main_en   = load_in || load_skid;
  assign main_d    = load_skid ? skid_q : in_data;
  assign skid_en   = !flush && (state == BUSY) && in_valid && !out_ready;

  stage_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  stage_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                        stall_cycles <= 32'd0;
    else if (out_valid && !out_ready) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
